// File: rtl/wb_cpu_master.sv
// wb_cpu_master: CPU load/store to single-beat classic Wishbone initiator; WB_TIMEOUT_EN adds an ack timeout abort
module wb_cpu_master #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int RD_LAT = 1,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_busy,
  output logic          cpu_err,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  output logic          we_o,
  output logic          stb_o,
  output logic          cyc_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i
);
  typedef enum logic [1:0] {IDLE, STROBE, RDWAIT, DONE} state_t;
  state_t state;
  logic [1:0] lat_cnt;
`ifdef WB_TIMEOUT_EN
  logic [15:0] to_cnt;
`else
  assign cpu_err = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      lat_cnt <= '0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_busy <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      we_o <= 1'b0;
      stb_o <= 1'b0;
      cyc_o <= 1'b0;
`ifdef WB_TIMEOUT_EN
      to_cnt <= '0;
      cpu_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          adr_o <= cpu_addr;
          dat_o <= cpu_wdata;
          we_o <= cpu_we;
          stb_o <= 1'b1;
          cyc_o <= 1'b1;
          cpu_busy <= 1'b1;
          state <= STROBE;
`ifdef WB_TIMEOUT_EN
          to_cnt <= '0;
`endif
        end
        STROBE: if (ack_i) begin
          stb_o <= 1'b0;
          if (we_o || RD_LAT == 0) begin
            if (!we_o) cpu_rdata <= dat_i;
            cpu_ready <= 1'b1;
            state <= DONE;
          end else begin
            lat_cnt <= 2'(RD_LAT);
            state <= RDWAIT;
          end
        end
`ifdef WB_TIMEOUT_EN
        else begin
          to_cnt <= to_cnt + 16'd1;
          if (to_cnt + 16'd1 == 16'(TIMEOUT)) begin
            stb_o <= 1'b0;
            cyc_o <= 1'b0;
            cpu_ready <= 1'b1;
            cpu_err <= 1'b1;
            state <= DONE;
          end
        end
`endif
        RDWAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) begin
            cpu_rdata <= dat_i;
            cpu_ready <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          cpu_ready <= 1'b0;
          cyc_o <= 1'b0;
          we_o <= 1'b0;
          cpu_busy <= 1'b0;
          state <= IDLE;
`ifdef WB_TIMEOUT_EN
          cpu_err <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_cpu_master.sv
// tb_wb_cpu_master: directed checks of wb_cpu_master against a registered-data Wishbone responder
module tb_wb_cpu_master;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata;
  logic cpu_ready, cpu_busy, cpu_err;
  logic [31:0] adr_o, dat_o, dat_i = 0;
  logic we_o, stb_o, cyc_o, ack_i;
  logic ack_en = 1;
  int ack_delay = 0, wcnt = 0;
  logic [31:0] rd_val = 0;
  int n_run = 0, n_fail = 0;
  wb_cpu_master #(.AW(32), .DW(32), .RD_LAT(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_busy(cpu_busy),
    .cpu_err(cpu_err), .adr_o(adr_o), .dat_o(dat_o), .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o),
    .dat_i(dat_i), .ack_i(ack_i)
  );
  always #5 clk = ~clk;
  // responder: ack combinational from stb after wcnt wait states, read data valid one cycle after ack
  assign ack_i = ack_en && stb_o && wcnt == 0;
  always @(posedge clk) begin
    wcnt <= !stb_o ? ack_delay : (wcnt != 0 ? wcnt - 1 : 0);
    dat_i <= (ack_i && !we_o) ? rd_val : 32'h0;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    tick(); tick();
    check("rst_busy", {31'b0, cpu_busy}, 0);
    check("rst_stb", {31'b0, stb_o}, 0);
    rst = 0;
    tick();
    check("rst_rdata", cpu_rdata, 0);
    check("rst_adr", adr_o, 0);
    check("rst_ready", {31'b0, cpu_ready}, 0);
    // write with zero wait states
    issue(1, 32'hFFFFFF00, 32'h000000A5);
    tick(); cpu_req = 0;
    check("wr_stb", {31'b0, stb_o}, 1);
    check("wr_adr", adr_o, 32'hFFFFFF00);
    check("wr_dat", dat_o, 32'h000000A5);
    check("wr_we", {31'b0, we_o}, 1);
    check("wr_busy1", {31'b0, cpu_busy}, 1);
    tick();
    check("wr_ready", {31'b0, cpu_ready}, 1);
    check("wr_err", {31'b0, cpu_err}, 0);
    check("wr_stb2", {31'b0, stb_o}, 0);
    tick();
    check("wr_busy3", {31'b0, cpu_busy}, 0);
    check("wr_ready3", {31'b0, cpu_ready}, 0);
    // read with RD_LAT=1, stale data during ack cycle
    rd_val = 32'h12345678;
    issue(0, 32'h00000040, 0);
    tick(); cpu_req = 0;
    check("rd_stb", {31'b0, stb_o}, 1);
    check("rd_we", {31'b0, we_o}, 0);
    tick();
    check("rd_stb2", {31'b0, stb_o}, 0);
    check("rd_cyc2", {31'b0, cyc_o}, 1);
    check("rd_ready2", {31'b0, cpu_ready}, 0);
    tick();
    check("rd_ready3", {31'b0, cpu_ready}, 1);
    check("rd_data", cpu_rdata, 32'h12345678);
    tick();
    check("rd_hold", cpu_rdata, 32'h12345678);
    check("rd_busy4", {31'b0, cpu_busy}, 0);
    // write with 5 wait states and a stray request while busy
    ack_delay = 5;
    issue(1, 32'h00000010, 32'h55AA55AA);
    tick(); cpu_req = 0;
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("dly_stb%0d", i), {31'b0, stb_o}, 1);
      check($sformatf("dly_adr%0d", i), adr_o, 32'h00000010);
      check($sformatf("dly_rdy%0d", i), {31'b0, cpu_ready}, 0);
      cpu_req = (i == 3);
      cpu_addr = 32'h0000BAD0;
      tick();
    end
    cpu_req = 0;
    ack_delay = 0;
    check("dly_ready", {31'b0, cpu_ready}, 1);
    tick();
    check("dly_idle_stb", {31'b0, stb_o}, 0);
    check("dly_idle_busy", {31'b0, cpu_busy}, 0);
    check("dly_rdata_kept", cpu_rdata, 32'h12345678);
    // back-to-back: second request raised on first cpu_ready and held
    issue(1, 32'hFFFFFF04, 32'h0000005A);
    tick(); cpu_req = 0;
    tick();
    check("b2b_ready1", {31'b0, cpu_ready}, 1);
    rd_val = 32'hCAFEF00D;
    issue(0, 32'hFFFFFE00, 0);
    check("b2b_done_stb", {31'b0, stb_o}, 0);
    tick();
    check("b2b_idle_stb", {31'b0, stb_o}, 0);
    check("b2b_idle_busy", {31'b0, cpu_busy}, 0);
    tick(); cpu_req = 0;
    check("b2b_stb2", {31'b0, stb_o}, 1);
    check("b2b_adr2", adr_o, 32'hFFFFFE00);
    tick(); tick();
    check("b2b_ready2", {31'b0, cpu_ready}, 1);
    check("b2b_rdata", cpu_rdata, 32'hCAFEF00D);
    tick();
    // reset during RDWAIT
    rd_val = 32'hDEADBEEF;
    issue(0, 32'h00000080, 32'h11111111);
    tick(); cpu_req = 0;
    tick();
    check("rw_cyc", {31'b0, cyc_o}, 1);
    rst = 1;
    tick();
    check("rw_rdata", cpu_rdata, 0);
    check("rw_outs", {cpu_ready, cpu_busy, cpu_err, we_o, stb_o, cyc_o}, 0);
    check("rw_adr", adr_o, 0);
    check("rw_dat", dat_o, 0);
    rst = 0;
    tick();
    check("rw_noready", {31'b0, cpu_ready}, 0);
    rd_val = 32'h0BADF00D;
    issue(0, 32'h00000084, 0);
    tick(); cpu_req = 0;
    tick(); tick();
    check("rw_fresh_ready", {31'b0, cpu_ready}, 1);
    check("rw_fresh_rdata", cpu_rdata, 32'h0BADF00D);
    tick();
`ifdef WB_TIMEOUT_EN
    ack_en = 0;
    issue(1, 32'h00000100, 32'h1);
    tick(); cpu_req = 0;
    for (int i = 1; i <= 8; i++) begin
      check($sformatf("to_stb%0d", i), {31'b0, stb_o}, 1);
      tick();
    end
    check("to_stb_drop", {31'b0, stb_o}, 0);
    check("to_cyc_drop", {31'b0, cyc_o}, 0);
    check("to_ready", {31'b0, cpu_ready}, 1);
    check("to_err", {31'b0, cpu_err}, 1);
    check("to_rdata", cpu_rdata, 32'h0BADF00D);
    tick();
    check("to_ready_end", {31'b0, cpu_ready}, 0);
    check("to_err_end", {31'b0, cpu_err}, 0);
    ack_en = 1;
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
